// File: rtl/challenge_poly_stream.sv
// Captures the challenge polynomial from the sampler, streams canonical residues in
// index order to the NTT coefficient memory, and checks the nonzero weight.
module challenge_poly_stream #(
  parameter int N      = 256,
  parameter int Q      = 8380417,
  parameter int TAU    = 49,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N*32-1:0]   c_in,
  input  logic              c_valid,
  output logic              c_ready,
  output logic [31:0]       coeff_data,
  output logic [ADDR_W-1:0] coeff_addr,
  output logic              coeff_valid,
  input  logic              coeff_ready,
  output logic              coeff_last,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   weight,
  output logic              weight_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [31:0]       Q_MINUS_1 = 32'(Q - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   W_MAX     = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W:0]   W_TAU     = (ADDR_W + 1)'(TAU);

  state_t              state_r;
  logic                armed_r;
  logic [31:0]         bank_r [N];
  logic [ADDR_W:0]     acc_r;
  logic                illegal_r;
  logic [ADDR_W-1:0]   next_idx_s;
  logic [31:0]         cur_s;

  // coeff_addr doubles as the stream index, so the bank entry on the bus is cur_s
  assign next_idx_s = coeff_addr + ADDR_W'(1);
  assign cur_s      = bank_r[coeff_addr];

  function automatic logic [31:0] map_coeff(input logic [31:0] v);
    case (v)
      32'h0000_0001: map_coeff = 32'd1;
      32'hFFFF_FFFF: map_coeff = Q_MINUS_1;
      default:       map_coeff = 32'd0;
    endcase
  endfunction

  function automatic logic is_unit(input logic [31:0] v);
    is_unit = (v == 32'h0000_0001) || (v == 32'hFFFF_FFFF);
  endfunction

  function automatic logic is_illegal(input logic [31:0] v);
    is_illegal = (v != 32'h0000_0000) && !is_unit(v);
  endfunction

  // Capture / stream / finish sequencing with all outputs registered
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      armed_r     <= 1'b1;
      c_ready     <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      coeff_valid <= 1'b0;
      coeff_last  <= 1'b0;
      coeff_data  <= 32'd0;
      coeff_addr  <= '0;
      weight      <= '0;
      weight_err  <= 1'b0;
      acc_r       <= '0;
      illegal_r   <= 1'b0;
      for (int i = 0; i < N; i++) bank_r[i] <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (c_valid && armed_r) begin
            for (int i = 0; i < N; i++) bank_r[i] <= c_in[32*i +: 32];
            armed_r     <= 1'b0;
            c_ready     <= 1'b0;
            busy        <= 1'b1;
            coeff_valid <= 1'b1;
            coeff_addr  <= '0;
            coeff_data  <= map_coeff(c_in[31:0]);
            coeff_last  <= 1'b0;
            acc_r       <= '0;
            illegal_r   <= 1'b0;
            weight      <= '0;
            weight_err  <= 1'b0;
            state_r     <= STREAM;
          end else if (!c_valid) begin
            // a level-held c_valid must drop before the next capture is allowed
            armed_r <= 1'b1;
            c_ready <= 1'b1;
          end else begin
            armed_r <= armed_r;
          end
        end
        STREAM: begin
          if (coeff_ready) begin
            if (is_unit(cur_s) && (acc_r != W_MAX)) acc_r <= acc_r + (ADDR_W + 1)'(1);
            if (is_illegal(cur_s)) illegal_r <= 1'b1;
            if (coeff_addr == LAST_IDX) begin
              coeff_valid <= 1'b0;
              coeff_last  <= 1'b0;
              state_r     <= FINISH;
            end else begin
              coeff_addr <= next_idx_s;
              coeff_data <= map_coeff(bank_r[next_idx_s]);
              coeff_last <= (next_idx_s == LAST_IDX);
            end
          end
        end
        FINISH: begin
          done       <= 1'b1;
          busy       <= 1'b0;
          weight     <= acc_r;
          weight_err <= (acc_r != W_TAU) || illegal_r;
          state_r    <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_challenge_poly_stream.sv
// Bench for challenge_poly_stream: table-driven polynomials plus random ones, checked
// against a reference model of the mapping and weight rules.
module tb_challenge_poly_stream;
  localparam int N = 256;
  localparam int Q = 8380417;
  localparam int TAU = 49;

  logic            clock = 1'b0;
  logic            reset;
  logic [N*32-1:0] c_in;
  logic            c_valid;
  logic            c_ready;
  logic [31:0]     coeff_data;
  logic [7:0]      coeff_addr;
  logic            coeff_valid;
  logic            coeff_ready;
  logic            coeff_last;
  logic            busy;
  logic            done;
  logic [8:0]      weight;
  logic            weight_err;

  challenge_poly_stream #(.N(N), .Q(Q), .TAU(TAU), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .c_in(c_in), .c_valid(c_valid), .c_ready(c_ready),
    .coeff_data(coeff_data), .coeff_addr(coeff_addr), .coeff_valid(coeff_valid),
    .coeff_ready(coeff_ready), .coeff_last(coeff_last), .busy(busy), .done(done),
    .weight(weight), .weight_err(weight_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          n_plus;
    int          n_minus;
    int          bad_idx;
    logic [31:0] bad_val;
    bit          stall;
    bit          hold;
    bit          disturb;
    int          exp_w;
    bit          exp_e;
  } vec_t;

  vec_t        vecs[8];
  logic [31:0] cur_poly[N];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference: +1 -> 1, -1 -> Q-1, anything else -> 0
  function automatic int ref_data(input logic [31:0] v);
    int s;
    s = $signed(v);
    if (s == 1) return 1;
    if (s == -1) return Q - 1;
    return 0;
  endfunction

  task automatic model(output int w, output bit e);
    int cnt;
    bit ill;
    cnt = 0;
    ill = 1'b0;
    for (int i = 0; i < N; i++) begin
      int s;
      s = $signed(cur_poly[i]);
      if (s == 1 || s == -1) cnt++;
      else if (s != 0) ill = 1'b1;
    end
    w = (cnt > N) ? N : cnt;
    e = (w != TAU) || ill;
  endtask

  task automatic build_poly(input vec_t v);
    int perm[N];
    int k;
    for (int i = 0; i < N; i++) begin
      perm[i] = i;
      cur_poly[i] = 32'd0;
    end
    for (int i = N - 1; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(0, i);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    k = 0;
    for (int i = 0; i < N; i++) begin
      if (perm[i] != v.bad_idx) begin
        if (k < v.n_plus) cur_poly[perm[i]] = 32'h0000_0001;
        else if (k < v.n_plus + v.n_minus) cur_poly[perm[i]] = 32'hFFFF_FFFF;
        k++;
      end
    end
    if (v.bad_idx >= 0) cur_poly[v.bad_idx] = v.bad_val;
  endtask

  task automatic build_random_poly();
    for (int i = 0; i < N; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70) cur_poly[i] = 32'd0;
      else if (r < 85) cur_poly[i] = 32'h0000_0001;
      else if (r < 99) cur_poly[i] = 32'hFFFF_FFFF;
      else cur_poly[i] = (32'($urandom) | 32'h0000_0002) & 32'h7FFF_FFFF;
    end
  endtask

  task automatic wait_armed(input string nm);
    int waitc;
    waitc = 0;
    while (!c_ready && waitc < 50) begin
      @(negedge clock);
      waitc++;
    end
    check_eq({nm, "_armed"}, int'(c_ready), 1);
  endtask

  task automatic run_stream(input bit stall, input bit hold, input bit disturb,
                            input int exp_w, input bit exp_e, input string nm);
    int t, done_t, exp_idx, order_err, data_err, last_err, hold_err, side_err, hold_bad;
    int w_done, e_done;
    bit prev_stall;
    logic [31:0] prev_data;
    logic [7:0] prev_addr;
    logic nr;
    wait_armed(nm);
    for (int i = 0; i < N; i++) c_in[32*i +: 32] = cur_poly[i];
    c_valid = 1'b1;
    coeff_ready = 1'b1;
    @(posedge clock);
    t = 0; done_t = -1; exp_idx = 0; prev_stall = 1'b0;
    order_err = 0; data_err = 0; last_err = 0; hold_err = 0; side_err = 0;
    w_done = -1; e_done = -1; prev_data = 32'd0; prev_addr = 8'd0;
    while (t < 3000 && done_t < 0) begin
      @(negedge clock);
      if (disturb && t == 40) begin
        c_valid = 1'b0;
        for (int i = 0; i < N; i++) c_in[32*i +: 32] = 32'($urandom);
      end
      if (disturb && t == 41) c_valid = 1'b1;
      if (coeff_valid) begin
        if (prev_stall && (coeff_data !== prev_data || coeff_addr !== prev_addr)) hold_err++;
        if (int'(coeff_addr) != exp_idx) order_err++;
        if (exp_idx < N && coeff_data !== 32'(ref_data(cur_poly[exp_idx]))) data_err++;
        if (coeff_last !== (coeff_addr == 8'd255)) last_err++;
        if (!busy || c_ready || weight != 9'd0 || weight_err) side_err++;
      end else if (coeff_last) begin
        last_err++;
      end
      if (done) begin
        done_t = t;
        w_done = int'(weight);
        e_done = int'(weight_err);
        if (!hold) c_valid = 1'b0;
      end
      nr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      coeff_ready = nr;
      prev_stall = coeff_valid && !nr;
      prev_data = coeff_data;
      prev_addr = coeff_addr;
      if (coeff_valid && nr) exp_idx++;
      t++;
    end
    check_eq({nm, "_beats"}, exp_idx, N);
    check_eq({nm, "_order_errs"}, order_err, 0);
    check_eq({nm, "_data_errs"}, data_err, 0);
    check_eq({nm, "_last_errs"}, last_err, 0);
    check_eq({nm, "_stall_hold_errs"}, hold_err, 0);
    check_eq({nm, "_busy_side_errs"}, side_err, 0);
    check_eq({nm, "_done_seen"}, int'(done_t >= 0), 1);
    if (!stall) check_eq({nm, "_done_latency"}, done_t, N + 1);
    check_eq({nm, "_weight"}, w_done, exp_w);
    check_eq({nm, "_weight_err"}, e_done, int'(exp_e));
    if (hold) begin
      hold_bad = 0;
      repeat (20) begin
        @(negedge clock);
        if (c_ready || coeff_valid || busy || done) hold_bad++;
      end
      check_eq({nm, "_held_valid_no_recapture"}, hold_bad, 0);
      c_valid = 1'b0;
    end
    @(negedge clock);
    check_eq({nm, "_done_one_cycle"}, int'(done), 0);
    check_eq({nm, "_rearm"}, int'(c_ready), 1);
    check_eq({nm, "_weight_stable"}, int'(weight), exp_w);
  endtask

  task automatic reset_mid_stream();
    int bad;
    build_poly(vecs[0]);
    wait_armed("rst");
    for (int i = 0; i < N; i++) c_in[32*i +: 32] = cur_poly[i];
    c_valid = 1'b1;
    coeff_ready = 1'b1;
    @(posedge clock);
    repeat (101) @(negedge clock);
    check_eq("rst_beat100_addr", int'(coeff_addr), 100);
    #2;
    reset = 1'b1;
    c_valid = 1'b0;
    #1;
    check_eq("rst_coeff_valid", int'(coeff_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_c_ready", int'(c_ready), 1);
    check_eq("rst_addr", int'(coeff_addr), 0);
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clock);
      if (done || coeff_valid || busy) bad++;
    end
    check_eq("rst_no_done_after_abort", bad, 0);
  endtask

  initial begin
    int rw;
    bit re;
    vecs[0] = '{30, 19, -1, 32'd0,          1'b0, 1'b0, 1'b0, 49,  1'b0};
    vecs[1] = '{30, 19, -1, 32'd0,          1'b1, 1'b0, 1'b0, 49,  1'b0};
    vecs[2] = '{30, 18, -1, 32'd0,          1'b0, 1'b0, 1'b0, 48,  1'b1};
    vecs[3] = '{30, 19, 5,  32'd2,          1'b0, 1'b0, 1'b0, 49,  1'b1};
    vecs[4] = '{30, 19, -1, 32'd0,          1'b0, 1'b1, 1'b0, 49,  1'b0};
    vecs[5] = '{25, 24, -1, 32'd0,          1'b1, 1'b0, 1'b1, 49,  1'b0};
    vecs[6] = '{200, 56, -1, 32'd0,         1'b0, 1'b0, 1'b0, 256, 1'b1};
    vecs[7] = '{0,  0,  9,  32'h8000_0000,  1'b1, 1'b0, 1'b0, 0,   1'b1};

    reset = 1'b1;
    c_valid = 1'b0;
    coeff_ready = 1'b1;
    c_in = '0;
    repeat (2) @(negedge clock);
    check_eq("reset_c_ready", int'(c_ready), 1);
    check_eq("reset_busy_done", int'({busy, done}), 0);
    check_eq("reset_valid_last", int'({coeff_valid, coeff_last}), 0);
    check_eq("reset_data", int'(coeff_data), 0);
    check_eq("reset_addr", int'(coeff_addr), 0);
    check_eq("reset_weight", int'({weight, weight_err}), 0);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 8; v++) begin
      build_poly(vecs[v]);
      run_stream(vecs[v].stall, vecs[v].hold, vecs[v].disturb,
                 vecs[v].exp_w, vecs[v].exp_e, $sformatf("vec%0d", v));
    end

    reset_mid_stream();
    build_poly(vecs[0]);
    run_stream(1'b0, 1'b0, 1'b0, 49, 1'b0, "after_reset");

    for (int r = 0; r < 4; r++) begin
      build_random_poly();
      model(rw, re);
      run_stream(r[0], 1'b0, 1'b0, rw, re, $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
